decode_stage: RTL and testbench

Parametrised RV32/RV64 instruction-decode stage with an integrated 2-read/1-write register file, operand forwarding, load-use stall detection and a registered ID/EX pipeline boundary using valid/ready handshakes. It sits between fetch and execute. It replaces the purely combinational decode path with one that produces fully resolved, sign-extended ALU operands one cycle after an instruction is accepted.

---
 rtl/decode_pkg.sv | 10 +
 rtl/regfile_2r1w.sv | 26 ++
 rtl/decode_stage.sv | 104 ++++++++++
 tb/tb_decode_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared operand-select encodings and instruction field positions for decode
package decode_pkg;
  localparam int RD_LSB = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int ZIMM_LSB = 15;
  localparam int ZIMM_W = 5;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO, OP1_IMM_Z} op1_sel_e;
  typedef enum logic [2:0] {OP2_RS2, OP2_ITYPE, OP2_STYPE, OP2_SBTYPE, OP2_UTYPE, OP2_UJTYPE, OP2_ZERO, OP2_ZERO_ALT} op2_sel_e;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two combinational read ports, one synchronous write port, hard-zero x0
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] regs [NREGS];
  // clear on reset, write any register but x0
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wen && waddr != '0)
      regs[waddr] <= wdata;
  assign rdata1 = raddr1 == '0 ? '0 : regs[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : regs[raddr2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode with regfile, forwarding, load-use stall and registered ID/EX handshake
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      op1_sel,
  input  logic [2:0]      op2_sel,
  input  logic            uses_rs1,
  input  logic            uses_rs2,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_wen,
  input  logic [AW-1:0]   ex_addr,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_wen,
  input  logic [AW-1:0]   mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst
);
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } id_ex_t;
  logic [AW-1:0] rs1, rs2;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_sb, imm_u, imm_uj, op1, op2;
  logic load_use, cap;
  id_ex_t q;
  assign rs1 = in_inst[RS1_LSB +: AW];
  assign rs2 = in_inst[RS2_LSB +: AW];
  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rf_rd1), .rdata2(rf_rd2),
    .wen(wb_en), .waddr(wb_addr), .wdata(wb_data)
  );
  assign rs1_val = rs1 == '0 ? '0
                 : (ex_wen && ex_addr == rs1 && !ex_is_load) ? ex_data
                 : (mem_wen && mem_addr == rs1) ? mem_data
                 : (wb_en && wb_addr == rs1) ? wb_data
                 : rf_rd1;
  assign rs2_val = rs2 == '0 ? '0
                 : (ex_wen && ex_addr == rs2 && !ex_is_load) ? ex_data
                 : (mem_wen && mem_addr == rs2) ? mem_data
                 : (wb_en && wb_addr == rs2) ? wb_data
                 : rf_rd2;
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_sb = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_uj = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign op1 = op1_sel == OP1_RS1 ? rs1_val
             : op1_sel == OP1_PC ? in_pc
             : op1_sel == OP1_ZERO ? '0
             : XLEN'(in_inst[ZIMM_LSB +: ZIMM_W]);
  assign op2 = op2_sel == OP2_RS2 ? rs2_val
             : op2_sel == OP2_ITYPE ? imm_i
             : op2_sel == OP2_STYPE ? imm_s
             : op2_sel == OP2_SBTYPE ? imm_sb
             : op2_sel == OP2_UTYPE ? imm_u
             : op2_sel == OP2_UJTYPE ? imm_uj
             : '0;
  assign load_use = ex_wen && ex_is_load && ex_addr != '0 &&
                    ((uses_rs1 && rs1 == ex_addr) || (uses_rs2 && rs2 == ex_addr));
  assign in_ready = (!out_valid || out_ready) && !load_use;
  assign cap = in_valid && in_ready;
  // ID/EX boundary: flush kills, capture loads, consume without refill empties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      q <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (cap) q <= '{op1: op1, op2: op2, rs2_data: rs2_val, rd: in_inst[RD_LSB +: AW], pc: in_pc, inst: in_inst};
    end
  assign out_op1 = q.op1;
  assign out_op2 = q.op2;
  assign out_rs2_data = q.rs2_data;
  assign out_rd = q.rd;
  assign out_pc = q.pc;
  assign out_inst = q.inst;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, uses_rs1, uses_rs2, wb_en, ex_wen, ex_is_load, mem_wen, flush, out_valid, out_ready;
  logic [31:0] in_inst, out_inst;
  logic [63:0] in_pc, wb_data, ex_data, mem_data, out_op1, out_op2, out_rs2_data, out_pc;
  logic [1:0] op1_sel;
  logic [2:0] op2_sel;
  logic [4:0] wb_addr, ex_addr, mem_addr, out_rd;
  int errors = 0;
  int checks = 0;
  logic [63:0] rf [32];
  logic m_valid;
  logic [63:0] m_op1, m_op2, m_rs2, m_pc;
  logic [4:0] m_rd;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_wen(ex_wen), .ex_addr(ex_addr), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_pc(out_pc), .out_inst(out_inst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] m, x;
    m = 64'd1 << bits;
    x = v & (m - 64'd1);
    return x[bits-1] ? x - m : x;
  endfunction

  function automatic logic [63:0] src(input logic [4:0] r);
    if (r == 0) return 64'd0;
    if (ex_wen && ex_addr == r && !ex_is_load) return ex_data;
    if (mem_wen && mem_addr == r) return mem_data;
    if (wb_en && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  function automatic logic [63:0] model_op2(input logic [31:0] i);
    logic [63:0] v;
    v = {32'd0, i};
    case (op2_sel)
      3'd0: return src(i[24:20]);
      3'd1: return sext(v >> 20, 12);
      3'd2: return sext(((v >> 25) << 5) | ((v >> 7) & 64'd31), 12);
      3'd3: return sext((((v >> 31) & 64'd1) << 12) | (((v >> 7) & 64'd1) << 11) |
                        (((v >> 25) & 64'd63) << 5) | (((v >> 8) & 64'd15) << 1), 13);
      3'd4: return sext(v & 64'hFFFF_F000, 32);
      3'd5: return sext((((v >> 31) & 64'd1) << 20) | (((v >> 12) & 64'd255) << 12) |
                        (((v >> 20) & 64'd1) << 11) | (((v >> 21) & 64'd1023) << 1), 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_op1(input logic [31:0] i);
    case (op1_sel)
      2'd0: return src(i[19:15]);
      2'd1: return in_pc;
      2'd2: return 64'd0;
      default: return ({32'd0, i} >> 15) & 64'd31;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    {m_op1, m_op2, m_rs2, m_pc, m_rd, m_inst} = '0;
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
  endtask

  task automatic cycle();
    logic ld, rdy, cap;
    logic [63:0] e1, e2, e3;
    #1;
    ld = ex_wen && ex_is_load && ex_addr != 0 &&
         ((uses_rs1 && in_inst[19:15] == ex_addr) || (uses_rs2 && in_inst[24:20] == ex_addr));
    rdy = (!m_valid || out_ready) && !ld;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    cap = in_valid && rdy;
    e1 = model_op1(in_inst);
    e2 = model_op2(in_inst);
    e3 = src(in_inst[24:20]);
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (cap) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (cap) begin
      m_op1 = e1; m_op2 = e2; m_rs2 = e3; m_rd = in_inst[11:7]; m_pc = in_pc; m_inst = in_inst;
    end
    if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid) begin
      chk("out_op1", out_op1, m_op1);
      chk("out_op2", out_op2, m_op2);
      chk("out_rs2_data", out_rs2_data, m_rs2);
      chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
      chk("out_pc", out_pc, m_pc);
      chk("out_inst", {32'd0, out_inst}, {32'd0, m_inst});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {in_valid, uses_rs1, uses_rs2, wb_en, ex_wen, ex_is_load, mem_wen, flush, out_ready} = '0;
    {in_inst, in_pc, wb_data, ex_data, mem_data, op1_sel, op2_sel, wb_addr, ex_addr, mem_addr} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_op1", out_op1, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    // ADDI x1,x0,5
    in_valid = 1; out_ready = 1; uses_rs1 = 1; in_inst = 32'h0050_0093; in_pc = 64'h100; op2_sel = 3'd1;
    cycle();
    chk("addi_op1", out_op1, 64'd0);
    chk("addi_op2", out_op2, 64'd5);
    chk("addi_rd", {59'd0, out_rd}, 64'd1);
    // EX beats MEM, then MEM alone
    in_inst = 32'h0001_8213; in_pc = 64'h104;
    ex_wen = 1; ex_addr = 5'd3; ex_data = 64'hAA; mem_wen = 1; mem_addr = 5'd3; mem_data = 64'hBB;
    cycle();
    chk("fwd_ex", out_op1, 64'hAA);
    ex_wen = 0;
    cycle();
    chk("fwd_mem", out_op1, 64'hBB);
    // load-use bubble then MEM forwarding
    mem_wen = 0; in_inst = 32'h0020_0333; in_pc = 64'h108; uses_rs2 = 1; op2_sel = 3'd0;
    ex_wen = 1; ex_is_load = 1; ex_addr = 5'd2; ex_data = 64'h9999;
    cycle();
    chk("load_use_stall", {63'd0, in_ready}, 64'd0);
    ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_addr = 5'd2; mem_data = 64'h1234;
    cycle();
    chk("load_use_mem_fwd", out_op2, 64'h1234);
    // WB write-through, then array, then x0 write discarded
    mem_wen = 0; uses_rs2 = 0; op2_sel = 3'd1;
    in_inst = 32'h0002_8393; in_pc = 64'h10C; wb_en = 1; wb_addr = 5'd5; wb_data = 64'hDEAD_BEEF;
    cycle();
    chk("wb_bypass", out_op1, 64'hDEAD_BEEF);
    wb_en = 0;
    cycle();
    chk("wb_array", out_op1, 64'hDEAD_BEEF);
    in_inst = 32'h0000_0393; wb_en = 1; wb_addr = 5'd0; wb_data = 64'hFFFF;
    cycle();
    chk("x0_bypass", out_op1, 64'd0);
    wb_en = 0;
    cycle();
    chk("x0_array", out_op1, 64'd0);
    // BEQ imm=-4
    in_inst = 32'hFE00_0EE3; op2_sel = 3'd3; uses_rs2 = 1;
    cycle();
    chk("beq_imm", out_op2, 64'hFFFF_FFFF_FFFF_FFFC);
    // backpressure holds outputs, flush kills
    out_ready = 0; in_inst = 32'h1234_5037; op2_sel = 3'd4; in_pc = 64'h200;
    repeat (3) cycle();
    chk("stall_inst", {32'd0, out_inst}, 64'hFE00_0EE3);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    // async reset mid-stall
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_op2", out_op2, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1;
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      in_inst = $urandom;
      in_inst[19:15] = 5'($urandom_range(0, 7));
      in_inst[24:20] = 5'($urandom_range(0, 7));
      in_pc = {$urandom, $urandom};
      op1_sel = 2'($urandom);
      op2_sel = 3'($urandom);
      uses_rs1 = 1'($urandom);
      uses_rs2 = 1'($urandom);
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
      ex_wen = $urandom_range(0, 2) == 0; ex_addr = 5'($urandom_range(0, 7));
      ex_is_load = 1'($urandom); ex_data = {$urandom, $urandom};
      mem_wen = 1'($urandom); mem_addr = 5'($urandom_range(0, 7)); mem_data = {$urandom, $urandom};
      flush = $urandom_range(0, 15) == 0;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
